// File: rtl/conv_scan_ctrl.sv
// conv_scan_ctrl: frame scheduler for the 3x3 convolution datapath.
// Walks the image in raster order, issues one pixel fetch per FETCH cycle,
// fires the convolver on every full window and writes results densely.
// Optional build macro: CONV_CTRL_TIMEOUT_EN adds a WAIT-state result timeout
// that sets the sticky timeout_err_o and aborts the frame.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | waiting for start_i
//   S_FETCH | one pixel read per cycle, window check at current row/col
//   S_FIRE  | one-cycle mult_en_o pulse to the convolver
//   S_WAIT  | waiting for result_valid_i (optionally bounded by TIMEOUT)
//   S_WRITE | out_we_o with current out_addr_o/out_data_o, then advance
//   S_DONE  | one-cycle done_o pulse, then back to idle
module conv_scan_ctrl #(
    parameter int IMAGE_WIDTH  = 128,
    parameter int IMAGE_HEIGHT = 128,
    parameter int FILTER_SIZE  = 3,
    parameter int OUT          = IMAGE_WIDTH - FILTER_SIZE + 1,
    parameter int PIX_AW       = 14,
    parameter int OUT_AW       = 14,
    parameter int TIMEOUT      = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              result_valid_i,
    input  logic [31:0]       result_i,
    output logic              pix_rd_en_o,
    output logic [PIX_AW-1:0] pix_addr_o,
    output logic              mult_en_o,
    output logic              out_we_o,
    output logic [OUT_AW-1:0] out_addr_o,
    output logic [31:0]       out_data_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              timeout_err_o
);

    localparam int COL_W = (IMAGE_WIDTH  > 1) ? $clog2(IMAGE_WIDTH)  : 1;
    localparam int ROW_W = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;

    localparam logic [COL_W-1:0]  COL_LAST = COL_W'(IMAGE_WIDTH - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(IMAGE_HEIGHT - 1);
    localparam logic [COL_W-1:0]  COL_FM1  = COL_W'(FILTER_SIZE - 1);
    localparam logic [ROW_W-1:0]  ROW_FM1  = ROW_W'(FILTER_SIZE - 1);
    // Final dense output address; the counter parks here after the last write.
    localparam logic [OUT_AW-1:0] OUT_LAST =
        OUT_AW'(OUT * (IMAGE_HEIGHT - FILTER_SIZE + 1) - 1);

    // Refuse to elaborate with a geometry the address counters cannot hold.
    if (FILTER_SIZE < 1 || FILTER_SIZE > IMAGE_WIDTH || FILTER_SIZE > IMAGE_HEIGHT ||
        OUT != IMAGE_WIDTH - FILTER_SIZE + 1 || TIMEOUT < 1 ||
        PIX_AW < $clog2(IMAGE_WIDTH * IMAGE_HEIGHT) ||
        OUT_AW < $clog2(OUT * (IMAGE_HEIGHT - FILTER_SIZE + 1))) begin : g_bad_cfg
        $error("conv_scan_ctrl: inconsistent parameter set");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_FIRE,
        S_WAIT,
        S_WRITE,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [ROW_W-1:0]    row_q, row_d;
    logic [COL_W-1:0]    col_q, col_d;
    // Linear pixel index kept alongside row/col so no multiplier is needed.
    logic [PIX_AW-1:0]   pix_q, pix_d;
    logic [OUT_AW-1:0]   out_addr_q, out_addr_d;
    logic [31:0]         data_q, data_d;
    logic                terr_q, terr_d;
    logic                advance;
    logic                window_ok;
    logic                last_pix;

`ifdef CONV_CTRL_TIMEOUT_EN
    localparam int             TO_W    = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT - 1);
    logic [TO_W-1:0]           to_cnt_q, to_cnt_d;
`endif

    assign window_ok = (row_q >= ROW_FM1) && (col_q >= COL_FM1);
    assign last_pix  = (row_q == ROW_LAST) && (col_q == COL_LAST);

    // Next-state, scan position and data path decisions.
    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        col_d      = col_q;
        pix_d      = pix_q;
        out_addr_d = out_addr_q;
        data_d     = data_q;
        terr_d     = terr_q;
        advance    = 1'b0;
`ifdef CONV_CTRL_TIMEOUT_EN
        to_cnt_d   = to_cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d    = S_FETCH;
                    row_d      = '0;
                    col_d      = '0;
                    pix_d      = '0;
                    out_addr_d = '0;
                    terr_d     = 1'b0;
                end
            end
            S_FETCH: begin
                if (window_ok) begin
                    state_d = S_FIRE;
                end else begin
                    advance = 1'b1;
                end
            end
            S_FIRE: begin
                state_d = S_WAIT;
`ifdef CONV_CTRL_TIMEOUT_EN
                to_cnt_d = TO_LOAD;
`endif
            end
            S_WAIT: begin
                if (result_valid_i) begin
                    data_d  = result_i;
                    state_d = S_WRITE;
                end
`ifdef CONV_CTRL_TIMEOUT_EN
                else if (to_cnt_q == '0) begin
                    terr_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    to_cnt_d = to_cnt_q - 1'b1;
                end
`endif
            end
            S_WRITE: begin
                if (out_addr_q != OUT_LAST) begin
                    out_addr_d = out_addr_q + 1'b1;
                end
                if (last_pix) begin
                    state_d = S_DONE;
                end else begin
                    advance = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (advance) begin
            pix_d = pix_q + 1'b1;
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    // State, counters and registered strobes decoded from the next state.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q     <= S_IDLE;
            row_q       <= '0;
            col_q       <= '0;
            pix_q       <= '0;
            out_addr_q  <= '0;
            data_q      <= '0;
            terr_q      <= 1'b0;
            pix_rd_en_o <= 1'b0;
            pix_addr_o  <= '0;
            mult_en_o   <= 1'b0;
            out_we_o    <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            pix_q       <= pix_d;
            out_addr_q  <= out_addr_d;
            data_q      <= data_d;
            terr_q      <= terr_d;
            pix_rd_en_o <= (state_d == S_FETCH);
            pix_addr_o  <= (state_d == S_FETCH) ? pix_d : '0;
            mult_en_o   <= (state_d == S_FIRE);
            out_we_o    <= (state_d == S_WRITE);
            busy_o      <= (state_d != S_IDLE);
            done_o      <= (state_d == S_DONE);
        end
    end

`ifdef CONV_CTRL_TIMEOUT_EN
    // WAIT-state down-counter; terminal count at zero means the result is late.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
    assign timeout_err_o = terr_q;
`else
    assign timeout_err_o = 1'b0;
`endif

    assign out_addr_o = out_addr_q;
    assign out_data_o = data_q;

endmodule
